param_register_file: RTL and testbench
======================================

Name: param_register_file

Overview:
- Parametrised successor to the 64x16 dual-read register file used by the microprocessor datapath.
- Generalised in data width and depth, with a dedicated write address port separate from the read addresses.
- Adds optional hardwired-zero register 0, optional write-to-read bypass, optional registered reads, and a sequential soft-clear engine with Busy/ClearDone handshake.
- Sits between the instruction decoder (addresses) and the ALU (operands and results).

Parameters:
- DATA_WIDTH, 16, bits per register.
- ADDR_WIDTH, 6, address bits; DEPTH = 2**ADDR_WIDTH registers.
- ZERO_REG, 0, 1 = register 0 always reads 0 and ignores writes.
- BYPASS, 1, 1 = a read of the address being written in the same cycle returns WriteData (write-first).
- READ_REGISTERED, 0, 0 = combinational reads; 1 = reads sampled on Clock, 1-cycle latency.

Ports:
- Clock  input  1  system clock, all state on rising edge.
- nReset  input  1  asynchronous, active-low reset.
- WriteEnable  input  1  write request for this cycle.
- WriteAddress  input  ADDR_WIDTH  target register.
- WriteData  input  DATA_WIDTH  data to write.
- ReadAddressA  input  ADDR_WIDTH  read port A address.
- ReadDataA  output  DATA_WIDTH  read port A data.
- ReadAddressB  input  ADDR_WIDTH  read port B address.
- ReadDataB  output  DATA_WIDTH  read port B data.
- Clear  input  1  soft-clear request (level sampled on Clock).
- Busy  output  1  clear engine active; writes are dropped.
- ClearDone  output  1  one-cycle pulse when the sweep completes.

Behaviour:
- Reset (nReset low, asynchronous):
  - All DEPTH registers = 0.
  - FSM = IDLE, clear pointer = 0, Busy = 0, ClearDone = 0.
  - Registered read outputs = 0.
  - Reset mid-sweep aborts the sweep; the next state after release is IDLE.
- Write:
  - Accepted = WriteEnable && !Busy.
  - On an accepted write, Registers[WriteAddress] <= WriteData at the rising edge.
  - With ZERO_REG=1, writes to address 0 are discarded.
- Read, READ_REGISTERED=0:
  - ReadDataX = Registers[ReadAddressX] combinationally.
  - BYPASS=1: if the write is accepted and WriteAddress == ReadAddressX (and the address is not the zero register), ReadDataX = WriteData in the same cycle.
- Read, READ_REGISTERED=1:
  - ReadDataX is registered and shows the value selected at the previous edge, using the same bypass rule.
  - Latency is 1 cycle.
- Zero register: with ZERO_REG=1, address 0 reads 0 on both ports regardless of bypass.
- Both ports may read the same address; both return identical data.
- Clear FSM states IDLE, SWEEP, DONE:
  - IDLE: Clear=1 at an edge -> SWEEP, pointer = 0. A write accepted in that same cycle still lands and is later cleared by the sweep.
  - SWEEP: each cycle Registers[pointer] <= 0 and pointer increments. When pointer == DEPTH-1, that register is cleared and the FSM -> DONE; the pointer wraps to 0.
  - DONE: ClearDone = 1 for exactly one cycle, then -> IDLE.
  - Busy = 1 in SWEEP and DONE; it is a registered output.
  - From the Clear-sampling edge, Busy stays high for DEPTH+1 cycles.
  - Clear while Busy is ignored; Clear held high through DONE starts a new sweep from IDLE on the next edge.
- During Busy:
  - Writes are dropped silently.
  - Bypass is inactive.
  - Reads return current array contents, which may be partially cleared.
- No X on outputs after reset for any address value.

Test Plan:
- Reset then read all 64 addresses on A and B -> all 0x0000; Busy=0, ClearDone=0.
- Write 0xBEEF to addr 5, then next cycle read A=5, B=5 -> both 0xBEEF. Same-cycle read of 5 with BYPASS=1 -> 0xBEEF during the write cycle.
- ZERO_REG=1: write 0x1234 to addr 0 -> ReadDataA at addr 0 = 0x0000. Write 0x1234 to addr 1 -> reads 0x1234.
- READ_REGISTERED=1: fill addr 10 = 0x00AA, change ReadAddressA to 10 -> 0x00AA appears exactly one edge later.
- Fill all registers with their address value, pulse Clear for 1 cycle:
  - Busy high for 65 cycles; ClearDone pulses once in cycle 65.
  - A write of 0xFFFF to addr 63 during Busy is dropped.
  - After completion all reads = 0.
- Assert nReset low mid-sweep at pointer 20 -> immediately Busy=0 and all registers 0; after release, a write to addr 3 is accepted normally.

Source files
------------

// File: rtl/param_register_file_if.sv
// Decoder/ALU-side bus of the parametrised register file: write port, two read
// ports and the soft-clear handshake.
interface param_register_file_if #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 6
);
    logic                  WriteEnable;
    logic [ADDR_WIDTH-1:0] WriteAddress;
    logic [DATA_WIDTH-1:0] WriteData;
    logic [ADDR_WIDTH-1:0] ReadAddressA;
    logic [DATA_WIDTH-1:0] ReadDataA;
    logic [ADDR_WIDTH-1:0] ReadAddressB;
    logic [DATA_WIDTH-1:0] ReadDataB;
    logic                  Clear;
    logic                  Busy;
    logic                  ClearDone;

    modport master (
        output WriteEnable, WriteAddress, WriteData, ReadAddressA, ReadAddressB, Clear,
        input  ReadDataA, ReadDataB, Busy, ClearDone
    );

    modport slave (
        input  WriteEnable, WriteAddress, WriteData, ReadAddressA, ReadAddressB, Clear,
        output ReadDataA, ReadDataB, Busy, ClearDone
    );
endinterface

// File: rtl/param_register_file.sv
// Parametrised dual-read register file with optional zero register, write-first
// bypass, registered reads and a one-register-per-cycle soft-clear sweep.
module param_register_file #(
    parameter int DATA_WIDTH      = 16,
    parameter int ADDR_WIDTH      = 6,
    parameter int ZERO_REG        = 0,
    parameter int BYPASS          = 1,
    parameter int READ_REGISTERED = 0
) (
    input  logic                    Clock,
    input  logic                    nReset,
    param_register_file_if.slave    bus
);
    localparam int DEPTH = 1 << ADDR_WIDTH;

    typedef enum logic [1:0] {IDLE, SWEEP, DONE} state_t;

    state_t                state;
    logic [ADDR_WIDTH-1:0] clear_ptr;
    logic                  busy_q;
    logic                  done_q;
    logic [DATA_WIDTH-1:0] regs [DEPTH];

    logic                  write_accept;
    logic                  write_store;
    logic                  zero_a, zero_b;
    logic                  hit_a, hit_b;
    logic [DATA_WIDTH-1:0] sel_a, sel_b;

    assign write_accept = bus.WriteEnable && !busy_q;
    assign write_store  = write_accept && !(ZERO_REG != 0 && bus.WriteAddress == '0);

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            state     <= IDLE;
            clear_ptr <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done_q <= 1'b0;
                    if (bus.Clear) begin
                        state     <= SWEEP;
                        clear_ptr <= '0;
                        busy_q    <= 1'b1;
                    end
                end
                SWEEP: begin
                    clear_ptr <= clear_ptr + 1'b1;
                    if (clear_ptr == '1) begin
                        state  <= DONE;
                        done_q <= 1'b1;
                    end
                end
                DONE: begin
                    state  <= IDLE;
                    busy_q <= 1'b0;
                    done_q <= 1'b0;
                end
                default: begin
                    state  <= IDLE;
                    busy_q <= 1'b0;
                    done_q <= 1'b0;
                end
            endcase
        end
    end

    // NOTE: the array is reset explicitly because reset must leave every register at zero, not X.
    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
        end else begin
            // Writes are blocked while busy, so they never collide with the sweep.
            if (write_store)     regs[bus.WriteAddress] <= bus.WriteData;
            if (state == SWEEP)  regs[clear_ptr]        <= '0;
        end
    end

    assign zero_a = (ZERO_REG != 0) && (bus.ReadAddressA == '0);
    assign zero_b = (ZERO_REG != 0) && (bus.ReadAddressB == '0);
    assign hit_a  = (BYPASS != 0) && write_accept && (bus.WriteAddress == bus.ReadAddressA);
    assign hit_b  = (BYPASS != 0) && write_accept && (bus.WriteAddress == bus.ReadAddressB);

    assign sel_a = zero_a ? '0 : (hit_a ? bus.WriteData : regs[bus.ReadAddressA]);
    assign sel_b = zero_b ? '0 : (hit_b ? bus.WriteData : regs[bus.ReadAddressB]);

    generate
        if (READ_REGISTERED != 0) begin : g_read_reg
            logic [DATA_WIDTH-1:0] rd_a_q, rd_b_q;

            always_ff @(posedge Clock or negedge nReset) begin
                if (!nReset) begin
                    rd_a_q <= '0;
                    rd_b_q <= '0;
                end else begin
                    rd_a_q <= sel_a;
                    rd_b_q <= sel_b;
                end
            end

            assign bus.ReadDataA = rd_a_q;
            assign bus.ReadDataB = rd_b_q;
        end else begin : g_read_comb
            assign bus.ReadDataA = sel_a;
            assign bus.ReadDataB = sel_b;
        end
    endgenerate

    assign bus.Busy      = busy_q;
    assign bus.ClearDone = done_q;
endmodule

// File: tb/tb_param_register_file.sv
// Bench for param_register_file: a combinational-read instance and a
// zero-register/registered-read instance share stimulus and a reference model.
module tb_param_register_file;
    localparam int DW    = 16;
    localparam int AW    = 6;
    localparam int DEPTH = 64;

    logic          clk   = 1'b0;
    logic          rst_n = 1'b0;
    logic          we    = 1'b0;
    logic          clr   = 1'b0;
    logic [AW-1:0] wa    = '0;
    logic [AW-1:0] ra    = '0;
    logic [AW-1:0] rb    = '0;
    logic [DW-1:0] wd    = '0;

    always #5 clk = ~clk;

    param_register_file_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus0 ();
    param_register_file_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus1 ();

    assign bus0.WriteEnable  = we;
    assign bus0.WriteAddress = wa;
    assign bus0.WriteData    = wd;
    assign bus0.ReadAddressA = ra;
    assign bus0.ReadAddressB = rb;
    assign bus0.Clear        = clr;
    assign bus1.WriteEnable  = we;
    assign bus1.WriteAddress = wa;
    assign bus1.WriteData    = wd;
    assign bus1.ReadAddressA = ra;
    assign bus1.ReadAddressB = rb;
    assign bus1.Clear        = clr;

    param_register_file #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ZERO_REG(0), .BYPASS(1),
                          .READ_REGISTERED(0)) dut0 (.Clock(clk), .nReset(rst_n), .bus(bus0));
    param_register_file #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ZERO_REG(1), .BYPASS(1),
                          .READ_REGISTERED(1)) dut1 (.Clock(clk), .nReset(rst_n), .bus(bus1));

    // Reference model: register contents per instance and edges elapsed since Clear was taken.
    logic [DW-1:0] mem0 [DEPTH];
    logic [DW-1:0] mem1 [DEPTH];
    int            since;
    logic [DW-1:0] exp1_a, exp1_b;

    int            n_cmp = 0;
    int            n_bad = 0;
    logic [DW-1:0] last_a0, last_b0;
    logic          last_busy, last_done;

    typedef struct {
        logic          we;
        logic [AW-1:0] wa;
        logic [DW-1:0] wd;
        logic [AW-1:0] ra;
        logic [AW-1:0] rb;
        logic [DW-1:0] exp_a0;
        logic [DW-1:0] exp_b0;
        logic [DW-1:0] exp_a1;
        logic [DW-1:0] exp_b1;
    } vec_t;

    vec_t vecs [7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < DEPTH; i++) begin
            mem0[i] = '0;
            mem1[i] = '0;
        end
        since  = 0;
        exp1_a = '0;
        exp1_b = '0;
    endtask

    task automatic step(input logic we_i, input logic [AW-1:0] wa_i, input logic [DW-1:0] wd_i,
                        input logic [AW-1:0] ra_i, input logic [AW-1:0] rb_i, input logic clr_i);
        logic          accept;
        logic [DW-1:0] e0a, e0b, n1a, n1b;
        @(negedge clk);
        we = we_i; wa = wa_i; wd = wd_i; ra = ra_i; rb = rb_i; clr = clr_i;
        #1;
        accept = we_i && (since == 0);
        e0a = (accept && wa_i == ra_i) ? wd_i : mem0[ra_i];
        e0b = (accept && wa_i == rb_i) ? wd_i : mem0[rb_i];
        n1a = (ra_i == 0) ? '0 : ((accept && wa_i == ra_i) ? wd_i : mem1[ra_i]);
        n1b = (rb_i == 0) ? '0 : ((accept && wa_i == rb_i) ? wd_i : mem1[rb_i]);
        check("comb_read_a", bus0.ReadDataA, e0a);
        check("comb_read_b", bus0.ReadDataB, e0b);
        check("reg_read_a_hold", bus1.ReadDataA, exp1_a);
        check("reg_read_b_hold", bus1.ReadDataB, exp1_b);
        last_a0 = bus0.ReadDataA;
        last_b0 = bus0.ReadDataB;

        @(posedge clk);
        #1;
        if (accept) begin
            mem0[wa_i] = wd_i;
            if (wa_i != 0) mem1[wa_i] = wd_i;
        end
        if (since >= 1 && since <= DEPTH) begin
            mem0[since-1] = '0;
            mem1[since-1] = '0;
        end
        if (since > 0)  since = (since == DEPTH + 1) ? 0 : since + 1;
        else if (clr_i) since = 1;
        exp1_a = n1a;
        exp1_b = n1b;

        check("reg_read_a", bus1.ReadDataA, exp1_a);
        check("reg_read_b", bus1.ReadDataB, exp1_b);
        check("busy0", bus0.Busy, since > 0);
        check("busy1", bus1.Busy, since > 0);
        check("clear_done0", bus0.ClearDone, since == DEPTH + 1);
        check("clear_done1", bus1.ClearDone, since == DEPTH + 1);
        last_busy = bus0.Busy;
        last_done = bus0.ClearDone;
    endtask

    task automatic fill_all();
        for (int i = 0; i < DEPTH; i++) step(1'b1, AW'(i), DW'(i), AW'(i), '0, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int busy_cnt, done_cnt, done_at;

        vecs[0] = '{1'b1, 6'd5,  16'hBEEF, 6'd5,  6'd5,  16'hBEEF, 16'hBEEF, 16'hBEEF, 16'hBEEF};
        vecs[1] = '{1'b0, 6'd0,  16'h0000, 6'd5,  6'd5,  16'hBEEF, 16'hBEEF, 16'hBEEF, 16'hBEEF};
        vecs[2] = '{1'b1, 6'd0,  16'h1234, 6'd0,  6'd1,  16'h1234, 16'h0000, 16'h0000, 16'h0000};
        vecs[3] = '{1'b1, 6'd1,  16'h1234, 6'd0,  6'd5,  16'h1234, 16'hBEEF, 16'h0000, 16'hBEEF};
        vecs[4] = '{1'b0, 6'd0,  16'h0000, 6'd1,  6'd2,  16'h1234, 16'h0000, 16'h1234, 16'h0000};
        vecs[5] = '{1'b1, 6'd10, 16'h00AA, 6'd9,  6'd10, 16'h0000, 16'h00AA, 16'h0000, 16'h00AA};
        vecs[6] = '{1'b0, 6'd0,  16'h0000, 6'd10, 6'd0,  16'h00AA, 16'h1234, 16'h00AA, 16'h0000};

        model_reset();
        #12;
        check("reset_busy", bus0.Busy, 1'b0);
        check("reset_clear_done", bus0.ClearDone, 1'b0);
        check("reset_reg_read_a", bus1.ReadDataA, '0);
        @(negedge clk);
        rst_n = 1'b1;

        // Every address reads zero after reset.
        for (int i = 0; i < DEPTH; i++) begin
            step(1'b0, '0, '0, AW'(i), AW'(DEPTH - 1 - i), 1'b0);
            check("reset_read_a", last_a0, '0);
        end

        for (int i = 0; i < 7; i++) begin
            step(vecs[i].we, vecs[i].wa, vecs[i].wd, vecs[i].ra, vecs[i].rb, 1'b0);
            check($sformatf("vec%0d_a0", i), last_a0, vecs[i].exp_a0);
            check($sformatf("vec%0d_b0", i), last_b0, vecs[i].exp_b0);
            check($sformatf("vec%0d_a1", i), bus1.ReadDataA, vecs[i].exp_a1);
            check($sformatf("vec%0d_b1", i), bus1.ReadDataB, vecs[i].exp_b1);
        end

        // Full sweep: busy length, single ClearDone, dropped write to 63.
        fill_all();
        step(1'b0, '0, '0, '0, '0, 1'b1);
        check("busy_after_clear", last_busy, 1'b1);
        busy_cnt = last_busy ? 1 : 0;
        done_cnt = 0;
        done_at  = 0;
        for (int k = 0; k < 100 && last_busy; k++) begin
            step(k == 3, 6'd63, 16'hFFFF, 6'd63, AW'($urandom), 1'b0);
            if (last_busy) busy_cnt++;
            if (last_done) begin
                done_cnt++;
                done_at = busy_cnt;
            end
        end
        check("sweep_finished", last_busy, 1'b0);
        check("busy_cycles", busy_cnt, DEPTH + 1);
        check("clear_done_count", done_cnt, 1);
        check("clear_done_cycle", done_at, DEPTH + 1);
        for (int i = 0; i < DEPTH; i++) begin
            step(1'b0, '0, '0, AW'(i), AW'(DEPTH - 1 - i), 1'b0);
            check("post_clear_read", last_a0, '0);
        end

        // Reset asserted mid-sweep with the pointer at 20.
        fill_all();
        step(1'b0, '0, '0, '0, '0, 1'b1);
        for (int k = 0; k < 20; k++) step(1'b0, '0, '0, 6'd30, 6'd19, 1'b0);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("midsweep_reset_busy0", bus0.Busy, 1'b0);
        check("midsweep_reset_busy1", bus1.Busy, 1'b0);
        check("midsweep_reset_done", bus0.ClearDone, 1'b0);
        check("midsweep_reset_read30", bus0.ReadDataA, '0);
        check("midsweep_reset_reg_read", bus1.ReadDataA, '0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        step(1'b1, 6'd3, 16'h5A5A, 6'd3, 6'd3, 1'b0);
        step(1'b0, '0, '0, 6'd3, 6'd40, 1'b0);
        check("write_after_reset", last_a0, 16'h5A5A);
        check("write_after_reset_reg", bus1.ReadDataA, 16'h5A5A);

        // Clear held high through DONE restarts the sweep from IDLE.
        for (int k = 0; k < 70; k++)
            step(1'b1, AW'($urandom), DW'($urandom), AW'($urandom), AW'($urandom), 1'b1);
        for (int k = 0; k < 100 && since > 0; k++)
            step(1'b0, '0, '0, AW'($urandom), AW'($urandom), 1'b0);
        check("held_clear_drained", last_busy, 1'b0);

        // Randomised traffic with occasional clears.
        for (int k = 0; k < 400; k++) begin
            logic [AW-1:0] a;
            a = AW'($urandom);
            step(1'($urandom), a, DW'($urandom),
                 ($urandom_range(0, 3) == 0) ? a : AW'($urandom),
                 ($urandom_range(0, 3) == 0) ? a : AW'($urandom),
                 $urandom_range(0, 49) == 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
